bloom_filter_unit: RTL and testbench

//  Responder side of the custom-instruction Bloom interface. Accepts INSERT / CHECK / CLEAR

---
 rtl/bloom_pkg.sv | 22 ++
 rtl/bloom_hash.sv | 17 +
 rtl/bloom_filter_unit.sv | 127 ++++++++++++
 tb/tb_bloom_filter_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared types and hash constants for the Bloom filter custom-instruction unit.
package bloom_pkg;

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpInsert = 2'b01,
    OpCheck  = 2'b10,
    OpClear  = 2'b11
  } bloom_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHash = 2'b01,
    StResp = 2'b10
  } bloom_state_e;

  // Element [k] is the multiplier of hash function k.
  localparam logic [3:0][31:0] HashMult = {
    32'h27D4EB2F, 32'hC2B2AE3D, 32'h85EBCA77, 32'h9E3779B1
  };

endpackage

// File: rtl/bloom_hash.sv
// Multiplicative hash: bit index = upper IdxW bits of the low 32 bits of key * HashMult[k].
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int unsigned IdxW = 8
) (
  input  logic [31:0]     key_i,
  input  logic [1:0]      k_i,
  output logic [IdxW-1:0] idx_o
);

  logic [31:0] prod;

  assign prod  = key_i * HashMult[k_i];
  assign idx_o = prod[31 -: IdxW];

endmodule

// File: rtl/bloom_filter_unit.sv
// Bloom filter responder: INSERT / CHECK / CLEAR over valid/ready, one hash probed per cycle.
module bloom_filter_unit
  import bloom_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned M_BITS = 256,
  parameter int unsigned K_HASH = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_match_o,
  output logic [CNT_W-1:0]  fill_count_o
);

  localparam int unsigned IdxW = $clog2(M_BITS);
  localparam logic [1:0] LastK = 2'(K_HASH - 1);
  localparam logic [CNT_W-1:0] FillOne = CNT_W'(1);

  bloom_state_e      state_q;
  bloom_op_e         op_q, req_op;
  logic [31:0]       key_q, key32;
  logic [1:0]        k_q;
  logic              hit_q;
  logic              req_ready_q, resp_valid_q, resp_match_q;
  logic [CNT_W-1:0]  fill_q;
  logic [M_BITS-1:0] bits_q;
  logic [IdxW-1:0]   idx;
  logic              bit_rd, last_k;

  assign req_op = bloom_op_e'(req_op_i);

  // Key is zero-extended or truncated to 32 bits before hashing.
  always_comb begin
    key32 = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < DATA_W) key32[i] = req_data_i[i];
    end
  end

  bloom_hash #(
    .IdxW(IdxW)
  ) u_hash (
    .key_i(key_q),
    .k_i  (k_q),
    .idx_o(idx)
  );

  assign bit_rd = bits_q[idx];
  assign last_k = (k_q == LastK);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      op_q         <= OpNop;
      key_q        <= '0;
      k_q          <= '0;
      hit_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_match_q <= 1'b0;
      fill_q       <= '0;
      bits_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            key_q       <= key32;
            k_q         <= '0;
            hit_q       <= 1'b1;
            unique case (req_op)
              OpInsert, OpCheck: state_q <= StHash;
              OpClear: begin
                bits_q       <= '0;
                fill_q       <= '0;
                resp_match_q <= 1'b0;
                resp_valid_q <= 1'b1;
                state_q      <= StResp;
              end
              OpNop: begin
                resp_match_q <= 1'b0;
                resp_valid_q <= 1'b1;
                state_q      <= StResp;
              end
            endcase
          end
        end
        StHash: begin
          // Read happens before this cycle's own set, so a fresh key reports a miss.
          hit_q <= hit_q & bit_rd;
          k_q   <= k_q + 2'd1;
          if (op_q == OpInsert) bits_q[idx] <= 1'b1;
          if (last_k || (op_q == OpCheck && !bit_rd)) begin
            resp_match_q <= hit_q & bit_rd;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
            if (op_q == OpInsert && fill_q != '1) fill_q <= fill_q + FillOne;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_match_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_match_o = resp_match_q;
  assign fill_count_o = fill_q;

endmodule

// File: tb/tb_bloom_filter_unit.sv
// Directed plus random bench for bloom_filter_unit with a reference bit-array model.
module tb_bloom_filter_unit;

  localparam int unsigned KHash = 3;
  localparam int unsigned MBits = 256;
  localparam int unsigned IdxW  = 8;
  localparam int          Bound = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_match;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [15:0] fill_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        match;
    logic [15:0] fill;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  bit          model[MBits];
  int          model_fill;
  logic [31:0] mult[4] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F};
  logic [31:0] pool[8];

  always #5 clk = ~clk;

  bloom_filter_unit #(
    .DATA_W(32),
    .M_BITS(MBits),
    .K_HASH(KHash),
    .CNT_W (16)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_data_i  (req_data),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_match_o(resp_match),
    .fill_count_o(fill_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event within %0d cycles", tag, Bound);
  endtask

  function automatic int hidx(input logic [31:0] key, input int k);
    logic [31:0] p;
    p = key * mult[k];
    return int'(p >> (32 - IdxW));
  endfunction

  function automatic exp_t model_step(input logic [1:0] op, input logic [31:0] key);
    exp_t e;
    int   ix;
    e.match = 1'b0;
    e.lat   = 1;
    case (op)
      2'b01: begin
        e.match = 1'b1;
        e.lat   = KHash + 1;
        for (int k = 0; k < KHash; k++) begin
          ix = hidx(key, k);
          if (!model[ix]) e.match = 1'b0;
          model[ix] = 1'b1;
        end
        if (model_fill < 65535) model_fill++;
      end
      2'b10: begin
        e.match = 1'b1;
        e.lat   = KHash + 1;
        for (int k = 0; k < KHash; k++) begin
          ix = hidx(key, k);
          if (!model[ix]) begin
            e.match = 1'b0;
            e.lat   = k + 2;
            break;
          end
        end
      end
      2'b11: begin
        for (int i = 0; i < MBits; i++) model[i] = 1'b0;
        model_fill = 0;
      end
      default: ;
    endcase
    e.fill = 16'(model_fill);
    return e;
  endfunction

  // Issue one request; hold > 0 stalls the response for that many cycles.
  task automatic do_req(input logic [1:0] op, input logic [31:0] key, input int hold);
    exp_t e;
    int   b, lat;
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_op     = op;
    req_data   = key;
    b = 0;
    while (req_ready !== 1'b1 && b < Bound) begin
      @(posedge clk); #1; b++;
    end
    if (b >= Bound) begin
      timeout("req_ready");
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      return;
    end
    sb.push_back(model_step(op, key));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    lat = 1;
    b   = 0;
    while (resp_valid !== 1'b1 && b < Bound) begin
      @(posedge clk); #1; lat++; b++;
    end
    e = sb.pop_front();
    if (b >= Bound) begin
      timeout("resp_valid");
      resp_ready = 1'b1;
      return;
    end
    check("latency", 32'(lat), 32'(e.lat));
    check("resp_match", 32'(resp_match), 32'(e.match));
    check("fill_count", 32'(fill_count), 32'(e.fill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_resp_match", 32'(resp_match), 32'(e.match));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] op;
    int         r;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_data   = '0;
    resp_ready = 1'b1;
    model_fill = 0;
    for (int i = 0; i < MBits; i++) model[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_match", 32'(resp_match), 32'd0);
    check("rst_fill", 32'(fill_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    do_req(2'b10, 32'hDEADBEEF, 0);   // miss on empty array, latency 2
    do_req(2'b01, 32'hDEADBEEF, 0);   // fresh insert, latency 4
    do_req(2'b10, 32'hDEADBEEF, 0);
    do_req(2'b01, 32'hDEADBEEF, 0);   // second insert reports present
    do_req(2'b01, 32'h12345678, 0);
    do_req(2'b00, 32'h0, 0);          // NOP
    do_req(2'b11, 32'h0, 0);          // CLEAR
    do_req(2'b10, 32'hDEADBEEF, 0);
    do_req(2'b01, 32'hCAFEF00D, 5);   // stalled response
    do_req(2'b10, 32'hCAFEF00D, 3);

    // Reset in the middle of an INSERT's hash phase.
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 32'hA5A5A5A5;
    r = 0;
    while (req_ready !== 1'b1 && r < Bound) begin
      @(posedge clk); #1; r++;
    end
    if (r >= Bound) timeout("mid_rst_req_ready");
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < MBits; i++) model[i] = 1'b0;
    model_fill = 0;
    @(posedge clk); #1;
    check("mid_rst_ready_after", 32'(req_ready), 32'd1);
    check("mid_rst_fill", 32'(fill_count), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    do_req(2'b10, 32'hA5A5A5A5, 0);
    do_req(2'b10, 32'hCAFEF00D, 0);

    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 10);
      if (r < 5) op = 2'b01;
      else if (r < 9) op = 2'b10;
      else if (r == 9) op = 2'b11;
      else op = 2'b00;
      do_req(op, pool[$urandom_range(0, 7)], (n % 13 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
